// File: rtl/video_fetch_pkg.sv
// Shared constants and helpers for the ping-pong video fetcher.
package video_fetch_pkg;

  localparam int WORD_W = 16;

  // Renderer consumes the high byte of each DRAM word first.
  function automatic logic [WORD_W-1:0] byteswap16(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/video_fetch_sync.sv
// Fetch-cycle phase counter, bank swap pulse generator and video_go window.
module video_fetch_sync
  import video_fetch_pkg::*;
#(
  parameter int CYC_LEN    = 16,
  parameter int SYNC_PHASE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cend,
  input  logic pre_cend,
  input  logic vpix,
  input  logic fetch_start,
  input  logic fetch_end,
  output logic video_go,
  output logic fetch_sync
);

  localparam int CTR_W = clog2(CYC_LEN);
  localparam logic [CTR_W-1:0] SYNC_VAL = CTR_W'(SYNC_PHASE);

  logic [CTR_W-1:0] ctr;

  // Request window: a start inside the vertical window wins over a stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      video_go <= 1'b0;
    end else if (fetch_start && vpix) begin
      video_go <= 1'b1;
    end else if (fetch_end) begin
      video_go <= 1'b0;
    end
  end

  // Phase counter advances per DRAM cycle; fetch_start realigns it to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr <= '0;
    end else if (cend) begin
      if (fetch_start) ctr <= '0;
      else             ctr <= ctr + 1'b1;
    end
  end

  // Registered from pre_cend so the pulse lands on the cend clock itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_sync <= 1'b0;
    end else begin
      fetch_sync <= pre_cend && (ctr == SYNC_VAL);
    end
  end

endmodule

// File: rtl/video_fetch_pp.sv
// Ping-pong video fetcher: one bank fills from the arbiter while the
// other, completed at the last fetch_sync, is presented to the renderer.
module video_fetch_pp
  import video_fetch_pkg::*;
#(
  parameter int WORDS      = 4,
  parameter int CYC_LEN    = 16,
  parameter int SYNC_PHASE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cend,
  input  logic                    pre_cend,
  input  logic                    vpix,
  input  logic                    fetch_start,
  input  logic                    fetch_end,
  input  logic [WORD_W-1:0]       video_data,
  input  logic                    video_strobe,
  output logic                    video_go,
  output logic                    fetch_sync,
  output logic [WORDS*WORD_W-1:0] pic_bits,
  output logic                    overrun,
  output logic                    underrun
);

  localparam int CNT_W = clog2(WORDS) + 1;
  localparam int IDX_W = (WORDS > 1) ? clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS);

  logic [WORD_W-1:0]       bank [2][WORDS];
  logic                    wr_bank;
  logic [CNT_W-1:0]        wr_cnt;
  logic [CNT_W-1:0]        fin_cnt;
  logic                    load_pend;
  logic                    wr_full;
  logic                    do_write;
  logic [IDX_W-1:0]        wr_idx;
  logic [WORDS*WORD_W-1:0] rd_image;

  video_fetch_sync #(
    .CYC_LEN    (CYC_LEN),
    .SYNC_PHASE (SYNC_PHASE)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .cend        (cend),
    .pre_cend    (pre_cend),
    .vpix        (vpix),
    .fetch_start (fetch_start),
    .fetch_end   (fetch_end),
    .video_go    (video_go),
    .fetch_sync  (fetch_sync)
  );

  assign wr_full  = (wr_cnt == FULL);
  assign do_write = video_strobe && !wr_full;
  assign wr_idx   = IDX_W'(wr_cnt);
  // Count including a strobe on this clock; on a swap clock this is the
  // final fill level of the bank being closed.
  assign fin_cnt  = wr_cnt + CNT_W'(do_write);

  // Bank storage: a strobe on the swap clock still lands in the old bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < WORDS; k++) begin
          bank[b][k] <= '0;
        end
      end
    end else if (do_write) begin
      bank[wr_bank][wr_idx] <= video_data;
    end
  end

  // Write pointer, bank select and the one-clock status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      load_pend <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      overrun   <= video_strobe && wr_full;
      load_pend <= fetch_sync;
      if (fetch_sync) begin
        wr_bank  <= ~wr_bank;
        wr_cnt   <= '0;
        underrun <= (fin_cnt != '0) && (fin_cnt < FULL);
      end else begin
        wr_cnt   <= fin_cnt;
        underrun <= 1'b0;
      end
    end
  end

  // Byte-swapped image of the bank not being written (the completed one).
  always_comb begin
    rd_image = '0;
    for (int k = 0; k < WORDS; k++) begin
      rd_image[k*WORD_W +: WORD_W] = byteswap16(bank[~wr_bank][k]);
    end
  end

  // Renderer register loads once per fetch cycle, the clock after the swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pic_bits <= '0;
    end else if (load_pend) begin
      pic_bits <= rd_image;
    end
  end

endmodule
